// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and sizing for the serial shift-register chain
package serial_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bit-counter width, shared with the receiving shift chain (WIDTH >= 2).
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter, MSB first, bit_en paced
module piso_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             bit_en,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sframe,
   output logic             slast
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             accept;

   // Last bit is being consumed on this edge; a new word may load in the same edge.
   assign last_bit  = (state == SHIFT) && (cnt == '0) && bit_en;
   assign din_ready = (state == IDLE) || last_bit;
   assign accept    = din_valid && din_ready;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else if (accept) begin
         state <= SHIFT;
         shreg <= din;
         cnt   <= CW'(WIDTH - 1);
      end else if (state == SHIFT && bit_en) begin
         if (cnt == '0) begin
            state <= IDLE;
            shreg <= '0;
         end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt - CW'(1);
         end
      end
   end

   // Outputs decode registered state only, so clr clears them without a clock.
   assign sout   = (state == SHIFT) && shreg[WIDTH-1];
   assign sframe = (state == SHIFT);
   assign slast  = (state == SHIFT) && (cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       clr;
   logic       bit_en;
   logic [3:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       sout;
   logic       sframe;
   logic       slast;
   logic [3:0] rx;

   int checks = 0;
   int errors = 0;

   piso_serializer #(.WIDTH(4)) dut (
      .clk(clk),
      .clr(clr),
      .bit_en(bit_en),
      .din(din),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .sout(sout),
      .sframe(sframe),
      .slast(slast)
   );

   always #5 clk = ~clk;

   // 4-stage serial-in receiver capturing framed bits.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) rx <= '0;
      else if (bit_en && sframe) rx <= {rx[2:0], sout};
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pat;
      logic [3:0] w;
      int b;
      int c;

      clr = 1'b1; bit_en = 1'b0; din_valid = 1'b0; din = 4'h0;
      #2;
      chk1("rst_sout", sout, 1'b0);
      chk1("rst_sframe", sframe, 1'b0);
      chk1("rst_slast", slast, 1'b0);
      chk1("rst_ready", din_ready, 1'b1);
      nxt(); nxt();
      clr = 1'b0;

      // single word 1011 with bit_en tied high
      din = 4'b1011; din_valid = 1'b1; bit_en = 1'b1;
      nxt();
      din_valid = 1'b0; din = 4'h0;
      pat = 8'b1011_0000;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1("single_sout", sout, pat[7-i]);
         chk1("single_sframe", sframe, 1'b1);
         chk1("single_slast", slast, i == 3);
         chk1("single_ready", din_ready, i == 3);
         nxt();
      end
      #1;
      chk1("single_end_sframe", sframe, 1'b0);
      chk1("single_end_sout", sout, 1'b0);
      chk1("single_end_slast", slast, 1'b0);

      // back-to-back A then 5
      din = 4'hA; din_valid = 1'b1;
      nxt();
      din = 4'h5;
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk1("stream_sout", sout, pat[7-i]);
         chk1("stream_sframe", sframe, 1'b1);
         chk1("stream_slast", slast, (i == 3) || (i == 7));
         chk1("stream_ready", din_ready, (i == 3) || (i == 7));
         nxt();
         if (i == 3) din_valid = 1'b0;
      end
      #1;
      chk1("stream_end_sframe", sframe, 1'b0);

      // slow rate: bit_en every third cycle
      w = 4'b1100;
      din = w; din_valid = 1'b1; bit_en = 1'b0;
      nxt();
      din_valid = 1'b0; din = 4'h0;
      b = 0; c = 0;
      while (b < 4 && c < 20) begin
         bit_en = (c % 3 == 2);
         #1;
         chk1("slow_sout", sout, w[3-b]);
         chk1("slow_sframe", sframe, 1'b1);
         chk1("slow_slast", slast, b == 3);
         nxt();
         if (bit_en) b++;
         c++;
      end
      bit_en = 1'b0;
      #1;
      chk1("slow_len", c == 12, 1'b1);
      chk1("slow_end_sframe", sframe, 1'b0);

      // backpressure: 3 waits behind C, earlier din value E is ignored
      bit_en = 1'b1;
      din = 4'hC; din_valid = 1'b1;
      nxt();
      din_valid = 1'b0;
      #1;
      chk1("bp_c1_sout", sout, 1'b1);
      nxt();
      din_valid = 1'b1; din = 4'hE;
      #1;
      chk1("bp_c2_ready", din_ready, 1'b0);
      chk1("bp_c2_sout", sout, 1'b1);
      nxt();
      din = 4'h3;
      #1;
      chk1("bp_c3_ready", din_ready, 1'b0);
      chk1("bp_c3_sout", sout, 1'b0);
      nxt();
      #1;
      chk1("bp_c4_ready", din_ready, 1'b1);
      chk1("bp_c4_slast", slast, 1'b1);
      chk1("bp_c4_sout", sout, 1'b0);
      nxt();
      din_valid = 1'b0; din = 4'hF;
      w = 4'h3;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1("bp_sout", sout, w[3-i]);
         chk1("bp_sframe", sframe, 1'b1);
         chk1("bp_slast", slast, i == 3);
         nxt();
      end
      #1;
      chk1("bp_end_sframe", sframe, 1'b0);

      // asynchronous abort during the second bit of F
      din = 4'hF; din_valid = 1'b1;
      nxt();
      din_valid = 1'b0;
      #1;
      chk1("abort_c1_sout", sout, 1'b1);
      nxt();
      #2;
      clr = 1'b1;
      #1;
      chk1("abort_sout", sout, 1'b0);
      chk1("abort_sframe", sframe, 1'b0);
      chk1("abort_slast", slast, 1'b0);
      chk1("abort_ready", din_ready, 1'b1);
      nxt();
      clr = 1'b0;
      #1;
      chk1("post_rst_ready", din_ready, 1'b1);
      chk1("post_rst_sframe", sframe, 1'b0);
      din = 4'h9; din_valid = 1'b1;
      nxt();
      din_valid = 1'b0;
      w = 4'h9;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1("rst9_sout", sout, w[3-i]);
         chk1("rst9_sframe", sframe, 1'b1);
         nxt();
      end

      // loopback into the receiving chain
      din = 4'b0110; din_valid = 1'b1;
      nxt();
      din_valid = 1'b0;
      nxt(); nxt(); nxt(); nxt();
      #1;
      chk4("loop_rx", rx, 4'b0110);
      chk1("loop_sframe", sframe, 1'b0);
      nxt(); nxt();
      #1;
      chk4("loop_rx_hold", rx, 4'b0110);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
